// File: rtl/mod_147_3_2_jabber_ctrl.sv
// Jabber controller: symbol timer, transmit-length timer and unjab quiet timer
// driving a four-state jab FSM that gates tx_en on its way to the PMA.
module mod_147_3_2_jabber_ctrl #(
   parameter int unsigned CNT_W           = 24,
   parameter int unsigned SYMB_CYCLES     = 10,
   parameter int unsigned XMIT_MAX_CYCLES = 50000,
   parameter int unsigned UNJAB_CYCLES    = 400000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       symb_timer_start,
   input  logic       tx_en,
   output logic       tx_en_out,
   output logic       jab,
   output logic       symb_timer_done,
   output logic       xmit_max_timer_done,
   output logic       unjab_timer_done,
   output logic [1:0] jab_state
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StTx    = 2'd1,
      StJab   = 2'd2,
      StUnjab = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] One       = CNT_W'(1);
   localparam logic [CNT_W-1:0] SymbLast  = CNT_W'(SYMB_CYCLES - 1);
   localparam logic [CNT_W-1:0] XmitLast  = CNT_W'(XMIT_MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] UnjabLast = CNT_W'(UNJAB_CYCLES - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_sc;
   logic [CNT_W-1:0] r_xc;
   logic [CNT_W-1:0] r_uc;
   logic [CNT_W-1:0] w_uc_nxt;
   logic             r_jab;
   logic             r_symb_done;
   logic             r_xmit_done;
   logic             r_unjab_done;
   logic             w_xmit_done_nxt;
   logic             w_unjab_done_nxt;
   logic             w_xc_clr;

   // Free-running symbol timer; a start pulse re-phases it and eats that edge's pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sc        <= '0;
         r_symb_done <= 1'b0;
      end else if (symb_timer_start) begin
         r_sc        <= '0;
         r_symb_done <= 1'b0;
      end else if (r_sc == SymbLast) begin
         r_sc        <= '0;
         r_symb_done <= 1'b1;
      end else begin
         r_sc        <= r_sc + One;
         r_symb_done <= 1'b0;
      end
   end

   assign w_xc_clr = !tx_en || (r_state == StJab) || (r_state == StUnjab);

   // Transmit-length counter: counts consecutive tx_en cycles, saturating.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_xc <= '0;
      end else if (w_xc_clr) begin
         r_xc <= '0;
      end else if (r_xc != '1) begin
         r_xc <= r_xc + One;
      end
   end

   // Next-state, unjab counter and done-pulse decode; tx_en wins all limit-edge races.
   always_comb begin
      w_state_nxt      = r_state;
      w_uc_nxt         = r_uc;
      w_xmit_done_nxt  = 1'b0;
      w_unjab_done_nxt = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (tx_en) w_state_nxt = StTx;
         end
         StTx: begin
            if (!tx_en) begin
               w_state_nxt = StIdle;
            end else if (r_xc == XmitLast) begin
               w_state_nxt     = StJab;
               w_xmit_done_nxt = 1'b1;
            end
         end
         StJab: begin
            w_uc_nxt = '0;
            if (!tx_en) begin
               w_state_nxt = StUnjab;
               w_uc_nxt    = One;
            end
         end
         StUnjab: begin
            if (tx_en) begin
               w_state_nxt = StJab;
               w_uc_nxt    = '0;
            end else if (r_uc == UnjabLast) begin
               w_state_nxt      = StIdle;
               w_uc_nxt         = '0;
               w_unjab_done_nxt = 1'b1;
            end else begin
               w_uc_nxt = r_uc + One;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State, unjab counter, jab flag (from next state) and done pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= StIdle;
         r_uc         <= '0;
         r_jab        <= 1'b0;
         r_xmit_done  <= 1'b0;
         r_unjab_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_uc         <= w_uc_nxt;
         r_jab        <= (w_state_nxt == StJab) || (w_state_nxt == StUnjab);
         r_xmit_done  <= w_xmit_done_nxt;
         r_unjab_done <= w_unjab_done_nxt;
      end
   end

   assign tx_en_out           = tx_en & ~r_jab;
   assign jab                 = r_jab;
   assign symb_timer_done     = r_symb_done;
   assign xmit_max_timer_done = r_xmit_done;
   assign unjab_timer_done    = r_unjab_done;
   assign jab_state           = r_state;

endmodule

// File: tb/tb_mod_147_3_2_jabber_ctrl.sv
// Bench for the jabber controller: directed scenarios plus a random run
// compared against a run-length model of the jabber rules.
module tb_mod_147_3_2_jabber_ctrl;

   localparam int S = 4;
   localparam int X = 8;
   localparam int U = 5;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       symb_timer_start = 1'b0;
   logic       tx_en = 1'b0;
   logic       tx_en_out;
   logic       jab;
   logic       symb_timer_done;
   logic       xmit_max_timer_done;
   logic       unjab_timer_done;
   logic [1:0] jab_state;

   int errors = 0;
   int checks = 0;

   // Reference model: edges since symbol anchor, tx run length, quiet length.
   int m_n = 0, m_run = 0, m_quiet = 0;
   bit m_jab = 0, m_sdone = 0, m_xdone = 0, m_udone = 0;

   mod_147_3_2_jabber_ctrl #(
      .CNT_W(24), .SYMB_CYCLES(S), .XMIT_MAX_CYCLES(X), .UNJAB_CYCLES(U)
   ) dut (
      .clk(clk), .reset_n(reset_n), .symb_timer_start(symb_timer_start), .tx_en(tx_en),
      .tx_en_out(tx_en_out), .jab(jab), .symb_timer_done(symb_timer_done),
      .xmit_max_timer_done(xmit_max_timer_done), .unjab_timer_done(unjab_timer_done),
      .jab_state(jab_state)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input bit rn, input bit tx, input bit st);
      if (!rn) begin
         m_n = 0; m_run = 0; m_quiet = 0; m_jab = 0;
         m_sdone = 0; m_xdone = 0; m_udone = 0;
      end else begin
         if (st) begin
            m_n = 0; m_sdone = 0;
         end else begin
            m_n++; m_sdone = (m_n % S) == 0;
         end
         m_xdone = 0; m_udone = 0;
         if (!m_jab) begin
            if (tx) begin
               m_run++;
               if (m_run == X) begin
                  m_jab = 1; m_xdone = 1; m_run = 0; m_quiet = 0;
               end
            end else m_run = 0;
         end else if (tx) begin
            m_quiet = 0;
         end else begin
            m_quiet++;
            if (m_quiet == U) begin
               m_jab = 0; m_udone = 1; m_quiet = 0;
            end
         end
      end
   endtask

   function automatic logic [1:0] model_state();
      if (!m_jab) return (m_run > 0) ? 2'd1 : 2'd0;
      return (m_quiet > 0) ? 2'd3 : 2'd2;
   endfunction

   // One clock edge with given inputs; outputs are sampled 1 time unit after it.
   task automatic tick(input bit rn, input bit tx, input bit st);
      reset_n = rn; tx_en = tx; symb_timer_start = st;
      @(posedge clk);
      #1;
      model_edge(rn, tx, st);
   endtask

   task automatic test_reset();
      tick(0, 0, 0);
      tick(0, 0, 0);
      checks++;
      if ({jab, jab_state, tx_en_out} !== 4'b0) begin
         errors++;
         $display("FAIL reset_state: jab=%b state=%0d tx_en_out=%b, want 0/0/0",
                  jab, jab_state, tx_en_out);
      end
      checks++;
      if ({symb_timer_done, xmit_max_timer_done, unjab_timer_done} !== 3'b0) begin
         errors++;
         $display("FAIL reset_done: dones=%b%b%b, want 000", symb_timer_done,
                  xmit_max_timer_done, unjab_timer_done);
      end
   endtask

   // Last reset edge was edge 0; pulses expected at edges 4, 8, 12.
   task automatic test_symb_idle();
      for (int e = 1; e <= 12; e++) begin
         tick(1, 0, 0);
         checks++;
         if (symb_timer_done !== ((e % S) == 0)) begin
            errors++;
            $display("FAIL symb_idle e=%0d: done=%b, want %b", e, symb_timer_done,
                     (e % S) == 0);
         end
         checks++;
         if ({jab, jab_state, tx_en_out} !== 4'b0) begin
            errors++;
            $display("FAIL idle_quiet e=%0d: jab=%b state=%0d out=%b, want 0/0/0", e, jab,
                     jab_state, tx_en_out);
         end
      end
   endtask

   task automatic test_short_burst();
      for (int i = 1; i < X; i++) begin
         tick(1, 1, 0);
         checks++;
         if ({jab, jab_state, tx_en_out, xmit_max_timer_done} !== 5'b00110) begin
            errors++;
            $display("FAIL short_burst i=%0d: jab=%b state=%0d out=%b xdone=%b, want 0/1/1/0",
                     i, jab, jab_state, tx_en_out, xmit_max_timer_done);
         end
      end
      tick(1, 0, 0);
      checks++;
      if ({jab, jab_state, tx_en_out, xmit_max_timer_done} !== 5'b00000) begin
         errors++;
         $display("FAIL short_burst_end: jab=%b state=%0d out=%b xdone=%b, want 0/0/0/0",
                  jab, jab_state, tx_en_out, xmit_max_timer_done);
      end
   endtask

   task automatic go_jab(input string tag);
      for (int i = 1; i <= X; i++) begin
         tick(1, 1, 0);
         checks++;
         if (i < X) begin
            if ({jab, jab_state, tx_en_out, xmit_max_timer_done} !== 5'b00110) begin
               errors++;
               $display("FAIL %s_pre i=%0d: jab=%b state=%0d out=%b xdone=%b, want 0/1/1/0",
                        tag, i, jab, jab_state, tx_en_out, xmit_max_timer_done);
            end
         end else if ({jab, jab_state, tx_en_out, xmit_max_timer_done} !== 5'b11001) begin
            errors++;
            $display("FAIL %s_onset: jab=%b state=%0d out=%b xdone=%b, want 1/2/0/1",
                     tag, jab, jab_state, tx_en_out, xmit_max_timer_done);
         end
      end
   endtask

   task automatic test_jab_onset();
      go_jab("jab");
      tick(1, 1, 0);
      checks++;
      if ({jab, jab_state, tx_en_out, xmit_max_timer_done} !== 5'b11000) begin
         errors++;
         $display("FAIL jab_hold: jab=%b state=%0d out=%b xdone=%b, want 1/2/0/0",
                  jab, jab_state, tx_en_out, xmit_max_timer_done);
      end
   endtask

   task automatic release_unjab(input string tag);
      for (int i = 1; i <= U; i++) begin
         tick(1, 0, 0);
         checks++;
         if (i < U) begin
            if ({jab, jab_state, unjab_timer_done} !== 4'b1110) begin
               errors++;
               $display("FAIL %s_wait i=%0d: jab=%b state=%0d udone=%b, want 1/3/0",
                        tag, i, jab, jab_state, unjab_timer_done);
            end
         end else if ({jab, jab_state, unjab_timer_done} !== 4'b0001) begin
            errors++;
            $display("FAIL %s_release: jab=%b state=%0d udone=%b, want 0/0/1",
                     tag, jab, jab_state, unjab_timer_done);
         end
      end
      tick(1, 0, 0);
      checks++;
      if (unjab_timer_done !== 1'b0) begin
         errors++;
         $display("FAIL %s_pulse_width: udone=%b, want 0", tag, unjab_timer_done);
      end
   endtask

   task automatic test_unjab();
      release_unjab("unjab");
   endtask

   task automatic test_unjab_restart();
      go_jab("restart");
      for (int i = 1; i < U; i++) tick(1, 0, 0);
      checks++;
      if (jab_state !== 2'd3) begin
         errors++;
         $display("FAIL restart_in_unjab: state=%0d, want 3", jab_state);
      end
      tick(1, 1, 0);
      checks++;
      if ({jab, jab_state, unjab_timer_done, tx_en_out} !== 5'b11000) begin
         errors++;
         $display("FAIL restart_limit_edge: jab=%b state=%0d udone=%b out=%b, want 1/2/0/0",
                  jab, jab_state, unjab_timer_done, tx_en_out);
      end
      release_unjab("restart");
   endtask

   task automatic test_reset_mid();
      go_jab("rmid");
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      checks++;
      if ({jab, jab_state, unjab_timer_done, xmit_max_timer_done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid_unjab: jab=%b state=%0d udone=%b xdone=%b, want 0/0/0/0",
                  jab, jab_state, unjab_timer_done, xmit_max_timer_done);
      end
      // A cleared xmit counter needs a full X high edges again.
      go_jab("post_reset");
      // Re-phase the symbol timer, then restart it on the edge that would pulse.
      tick(1, 0, 1);
      checks++;
      if (symb_timer_done !== 1'b0) begin
         errors++;
         $display("FAIL symb_start_edge: done=%b, want 0", symb_timer_done);
      end
      for (int k = 0; k < 2; k++) begin
         for (int i = 1; i <= S; i++) begin
            tick(1, 0, (k == 1) && (i == S));
            checks++;
            if (symb_timer_done !== ((k == 0) && (i == S))) begin
               errors++;
               $display("FAIL symb_restart k=%0d i=%0d: done=%b, want %b", k, i,
                        symb_timer_done, (k == 0) && (i == S));
            end
         end
      end
      for (int i = 1; i <= S; i++) begin
         tick(1, 0, 0);
         checks++;
         if (symb_timer_done !== (i == S)) begin
            errors++;
            $display("FAIL symb_after_suppress i=%0d: done=%b, want %b", i, symb_timer_done,
                     i == S);
         end
      end
   endtask

   task automatic test_random();
      bit tx = 0;
      bit rn, st;
      tick(0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) tx = ~tx;
         rn = ($urandom_range(0, 299) != 0);
         st = ($urandom_range(0, 19) == 0);
         tick(rn, tx, st);
         checks++;
         if ({jab, jab_state, tx_en_out} !== {m_jab, model_state(), tx & ~m_jab}) begin
            errors++;
            $display("FAIL random_fsm i=%0d: jab=%b state=%0d out=%b, want %b/%0d/%b", i,
                     jab, jab_state, tx_en_out, m_jab, model_state(), tx & ~m_jab);
         end
         checks++;
         if ({symb_timer_done, xmit_max_timer_done, unjab_timer_done} !==
             {m_sdone, m_xdone, m_udone}) begin
            errors++;
            $display("FAIL random_done i=%0d: dones=%b%b%b, want %b%b%b", i,
                     symb_timer_done, xmit_max_timer_done, unjab_timer_done,
                     m_sdone, m_xdone, m_udone);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_symb_idle();
      test_short_burst();
      test_jab_onset();
      test_unjab();
      test_unjab_restart();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
